// File: rtl/trainled2_encoder.sv
// Serial encoder for a chain of TrainLED2 pixels: 24-bit colour words become
// pulse-width-coded bit cells, with a low latch gap closing each frame.
module trainled2_encoder #(
   parameter int T_BIT   = 32,
   parameter int T0H     = 8,
   parameter int T1H     = 20,
   parameter int T_LATCH = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] in_data,
   input  logic        in_valid,
   input  logic        in_last,
   output logic        in_ready,
   output logic        dout,
   output logic        busy,
   output logic        underrun
);

   localparam int CNT_MAX = (T_BIT > T_LATCH) ? T_BIT : T_LATCH;
   localparam int CW      = $clog2(CNT_MAX);

   localparam logic [CW-1:0] CELL_LAST  = CW'(T_BIT - 1);
   localparam logic [CW-1:0] LATCH_LAST = CW'(T_LATCH - 1);
   localparam logic [CW-1:0] HI1_LAST   = CW'(T1H - 1);
   localparam logic [CW-1:0] HI0_LAST   = CW'(T0H - 1);

   typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [4:0]    bit_idx, bit_idx_nx;
   logic [23:0]   shreg, shreg_nx;
   logic          last_r, last_nx;
   logic          dout_nx, underrun_nx;
   logic          cell_end, word_end, accept;

   assign cell_end = (state == LOW) && (cnt == CELL_LAST);
   assign word_end = cell_end && (bit_idx == 5'd0);

   // A follow-on word may only slip in at the very last cycle of a non-final word.
   assign in_ready = !rst && ((state == IDLE) || (word_end && !last_r));
   assign accept   = in_valid && in_ready;
   assign busy     = (state != IDLE);

   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      state_nx    = state;
      cnt_nx      = cnt + 1'b1;
      bit_idx_nx  = bit_idx;
      shreg_nx    = shreg;
      last_nx     = last_r;
      dout_nx     = dout;
      underrun_nx = 1'b0;

      case (state)
         IDLE: begin
            cnt_nx = '0;
         end
         HIGH: begin
            if (cnt == (shreg[23] ? HI1_LAST : HI0_LAST)) begin
               state_nx = LOW;
               dout_nx  = 1'b0;
            end
         end
         LOW: begin
            if (cell_end) begin
               cnt_nx = '0;
               if (bit_idx != 5'd0) begin
                  bit_idx_nx = bit_idx - 1'b1;
                  shreg_nx   = {shreg[22:0], 1'b0};
                  state_nx   = HIGH;
                  dout_nx    = 1'b1;
               end else begin
                  state_nx    = LATCH;
                  underrun_nx = !last_r;
               end
            end
         end
         LATCH: begin
            if (cnt == LATCH_LAST) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
            dout_nx  = 1'b0;
         end
      endcase

      // Acceptance overrides both the IDLE hold and the end-of-word latch entry.
      if (accept) begin
         state_nx    = HIGH;
         cnt_nx      = '0;
         bit_idx_nx  = 5'd23;
         shreg_nx    = in_data;
         last_nx     = in_last;
         dout_nx     = 1'b1;
         underrun_nx = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         bit_idx  <= 5'd0;
         shreg    <= '0;
         last_r   <= 1'b0;
         dout     <= 1'b0;
         underrun <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         bit_idx  <= bit_idx_nx;
         shreg    <= shreg_nx;
         last_r   <= last_nx;
         dout     <= dout_nx;
         underrun <= underrun_nx;
      end
   end

endmodule

// File: tb/tb_trainled2_encoder.sv
// Directed bench for trainled2_encoder: waveform model, loopback pixel decoder,
// and hand-computed cycle checkpoints.
module tb_trainled2_encoder;

   localparam int T_BIT   = 32;
   localparam int T0H     = 8;
   localparam int T1H     = 20;
   localparam int T_LATCH = 256;
   localparam int WORD    = 24 * T_BIT;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [23:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic        in_ready, dout, busy, underrun;

   int n_cmp = 0;
   int n_bad = 0;
   int n_under = 0;

   always #5 clk = ~clk;

   trainled2_encoder #(
      .T_BIT(T_BIT), .T0H(T0H), .T1H(T1H), .T_LATCH(T_LATCH)
   ) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_last(in_last), .in_ready(in_ready), .dout(dout), .busy(busy),
      .underrun(underrun)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Expected line level at position p (0-based) within a word.
   function automatic logic exp_dout(input logic [23:0] w, input int p);
      int b;
      int th;
      b  = 23 - p / T_BIT;
      th = w[b] ? T1H : T0H;
      return (p % T_BIT) < th;
   endfunction

   // Single-pixel receiver: keeps the first 24 bits, latches on a long low gap.
   logic [23:0] led = '0;
   logic [23:0] rx_sh = '0;
   int          hi_run = 0, lo_run = 0, rx_bits = 0;
   logic        prev = 1'b0;

   always @(negedge clk) begin
      if (underrun === 1'b1) n_under++;
      if (rst) begin
         hi_run = 0; lo_run = 0; rx_bits = 0; prev = 1'b0;
      end else begin
         if (dout) begin
            hi_run++;
            lo_run = 0;
         end else begin
            if (prev) begin
               if (rx_bits < 24) rx_sh = {rx_sh[22:0], (hi_run > (T0H + T1H) / 2)};
               rx_bits++;
               hi_run = 0;
            end
            lo_run++;
            if (lo_run == 200 && rx_bits > 0) begin
               if (rx_bits >= 24) led = rx_sh;
               rx_bits = 0;
            end
         end
         prev = dout;
      end
   end

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check(tag, {31'd0, busy}, 32'd0);
      @(negedge clk);
   endtask

   // Sends one word (held valid only for the accepting cycle) and checks its waveform.
   task automatic send_word(input string tag, input logic [23:0] w, input logic last);
      int errs;
      errs = 0;
      in_data = w; in_last = last; in_valid = 1'b1;
      check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
      for (int k = 1; k <= WORD; k++) begin
         @(negedge clk);
         if (k == 1) begin in_valid = 1'b0; in_data = ~w; end
         if (dout !== exp_dout(w, k - 1)) errs++;
      end
      check({tag, "_wave_errs"}, errs, 0);
   endtask

   initial begin
      int errs, ones, rdy, acc_k, u0;

      // Reset state
      @(negedge clk);
      check("rst_ready", {31'd0, in_ready}, 32'd0);
      check("rst_dout", {31'd0, dout}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_underrun", {31'd0, underrun}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Single final word 0xA50000
      errs = 0; ones = 0; rdy = 0;
      in_data = 24'hA50000; in_last = 1'b1; in_valid = 1'b1;
      check("t1_ready_idle", {31'd0, in_ready}, 32'd1);
      for (int k = 1; k <= WORD + T_LATCH + 1; k++) begin
         @(negedge clk);
         if (k == 1) begin in_valid = 1'b0; in_data = 24'hFFFFFF; end
         if (k <= WORD) begin
            if (dout !== exp_dout(24'hA50000, k - 1)) errs++;
         end else if (k <= WORD + T_LATCH) begin
            if (dout !== 1'b0) ones++;
            if (in_ready !== 1'b0) rdy++;
         end
         if (k == 20) check("t1_c0_hi_end", {31'd0, dout}, 32'd1);
         if (k == 21) check("t1_c0_lo_start", {31'd0, dout}, 32'd0);
         if (k == 40) check("t1_c1_hi_end", {31'd0, dout}, 32'd1);
         if (k == 41) check("t1_c1_lo_start", {31'd0, dout}, 32'd0);
         if (k == WORD) check("t1_ready_last_cyc", {31'd0, in_ready}, 32'd0);
         if (k == WORD + T_LATCH) check("t1_busy_latch_end", {31'd0, busy}, 32'd1);
         if (k == WORD + T_LATCH + 1) begin
            check("t1_ready_1025", {31'd0, in_ready}, 32'd1);
            check("t1_busy_1025", {31'd0, busy}, 32'd0);
         end
      end
      check("t1_wave_errs", errs, 0);
      check("t1_latch_high", ones, 0);
      check("t1_latch_ready", rdy, 0);
      check("t1_led", {8'd0, led}, 32'h00A50000);

      // Back-to-back words 0xFFFFFF (not last) then 0x000000 (last)
      errs = 0; acc_k = -1; u0 = n_under;
      in_data = 24'hFFFFFF; in_last = 1'b0; in_valid = 1'b1;
      for (int k = 1; k <= 2 * WORD; k++) begin
         @(negedge clk);
         if (k == 1) begin in_data = 24'h000000; in_last = 1'b1; end
         if (in_valid && in_ready) begin
            if (acc_k < 0) acc_k = k;
         end else if (acc_k > 0) begin
            in_valid = 1'b0;
         end
         if (acc_k > 0 && k > acc_k) in_valid = 1'b0;
         if (k <= WORD) begin
            if (dout !== exp_dout(24'hFFFFFF, k - 1)) errs++;
         end else begin
            if (dout !== exp_dout(24'h000000, k - 1 - WORD)) errs++;
         end
      end
      in_valid = 1'b0;
      check("t2_accept_cycle", acc_k, WORD);
      check("t2_wave_errs", errs, 0);
      wait_idle("t2_idle");
      check("t2_underrun", n_under - u0, 0);
      check("t2_led", {8'd0, led}, 32'h00FFFFFF);

      // Non-final word with no follow-up: underrun then latch
      u0 = n_under;
      in_data = 24'h800001; in_last = 1'b0; in_valid = 1'b1;
      for (int k = 1; k <= WORD + T_LATCH + 1; k++) begin
         @(negedge clk);
         if (k == 1) in_valid = 1'b0;
         if (k == WORD) check("t3_ready_last_cyc", {31'd0, in_ready}, 32'd1);
         if (k == WORD + 1) check("t3_underrun_pulse", {31'd0, underrun}, 32'd1);
         if (k == WORD + 2) check("t3_underrun_drop", {31'd0, underrun}, 32'd0);
         if (k == WORD + T_LATCH) check("t3_ready_latch_end", {31'd0, in_ready}, 32'd0);
         if (k == WORD + T_LATCH + 1) check("t3_ready_idle", {31'd0, in_ready}, 32'd1);
      end
      check("t3_underrun_count", n_under - u0, 1);
      check("t3_led", {8'd0, led}, 32'h00800001);

      // in_valid held high through the word and its latch
      errs = 0; ones = 0; rdy = 0;
      in_data = 24'h0F0F0F; in_last = 1'b1; in_valid = 1'b1;
      for (int k = 1; k <= WORD + T_LATCH + 1 + WORD; k++) begin
         @(negedge clk);
         if (k == 1) in_data = 24'hFFFFFF;
         if (k <= WORD + T_LATCH) begin
            if (in_ready !== 1'b0) rdy++;
            if (k > WORD && dout !== 1'b0) ones++;
         end
         if (k == WORD + T_LATCH + 1) begin
            check("t4_ready_idle", {31'd0, in_ready}, 32'd1);
            check("t4_led_first", {8'd0, led}, 32'h000F0F0F);
         end
         if (k == WORD + T_LATCH + 2) in_valid = 1'b0;
         if (k > WORD + T_LATCH + 1) begin
            if (dout !== exp_dout(24'hFFFFFF, k - (WORD + T_LATCH + 2))) errs++;
         end
      end
      check("t4_ready_blocked", rdy, 0);
      check("t4_latch_high", ones, 0);
      check("t4_second_wave", errs, 0);
      wait_idle("t4_idle");
      check("t4_led_second", {8'd0, led}, 32'h00FFFFFF);

      // Reset in mid-word at cycle 300
      in_data = 24'hC3C3C3; in_last = 1'b1; in_valid = 1'b1;
      for (int k = 1; k < 300; k++) begin
         @(negedge clk);
         if (k == 1) in_valid = 1'b0;
      end
      @(negedge clk);
      check("t5_dout_before", {31'd0, dout}, 32'd1);
      rst = 1'b1;
      #1;
      check("t5_dout_rst", {31'd0, dout}, 32'd0);
      check("t5_busy_rst", {31'd0, busy}, 32'd0);
      check("t5_ready_rst", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("t5_ready_after", {31'd0, in_ready}, 32'd1);
      send_word("t5", 24'h5A5A5A, 1'b1);
      wait_idle("t5_idle");
      check("t5_led", {8'd0, led}, 32'h005A5A5A);

      // Loopback into one pixel
      send_word("t6", 24'h123456, 1'b1);
      wait_idle("t6_idle");
      check("t6_led1", {24'd0, led[23:16]}, 32'h12);
      check("t6_led2", {24'd0, led[15:8]}, 32'h34);
      check("t6_led3", {24'd0, led[7:0]}, 32'h56);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
